mem_line_arbiter: RTL and testbench

Sequencing and arbitration controller for a bank of 8-bit memory lines. It shares one bank of 2^ADDR_W lines between two requesters using round-robin arbitration. For each access it drives the bank's one-hot line select, read-enable, write-enable and write-data bus, and samples the bank's shared read bus. After every reset it clears all lines to zero before accepting requests.

---
 rtl/mem_line_arbiter.sv | 139 +++++++++++++
 tb/tb_mem_line_arbiter.sv | 346 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_line_arbiter.sv
// Round-robin arbiter sharing one bank of 8-bit memory lines between two requesters.
// The bank is zeroed after every reset before any request is granted.
//
// state  | meaning
// CLEAR  | walking cnt over every line, writing zero
// IDLE   | waiting for a request; round-robin pick on a tie
// ACCESS | one-cycle bank read or write for the latched owner
// ACK    | one-cycle completion pulse to the owner
module mem_line_arbiter #(
    parameter int ADDR_W = 2,
    localparam int LINES = 1 << ADDR_W
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              req0,
    input  logic              req1,
    input  logic              we0,
    input  logic              we1,
    input  logic [ADDR_W-1:0] addr0,
    input  logic [ADDR_W-1:0] addr1,
    input  logic [7:0]        wdata0,
    input  logic [7:0]        wdata1,
    output logic              ack0,
    output logic              ack1,
    output logic [7:0]        rdata0,
    output logic [7:0]        rdata1,
    output logic [LINES-1:0]  mem_select,
    output logic              mem_rE,
    output logic              mem_wE,
    output logic [7:0]        mem_wdata,
    input  logic [7:0]        mem_rdata,
    output logic              busy
);

    typedef enum logic [1:0] {CLEAR, IDLE, ACCESS, ACK} state_t;

    state_t            state;
    logic [ADDR_W-1:0] cnt;
    logic              owner;
    logic              last;
    logic              lat_we;
    logic [ADDR_W-1:0] lat_addr;
    logic [7:0]        lat_wdata;

    logic              gnt_valid;
    logic              gnt_id;
    logic              gnt_we;
    logic [ADDR_W-1:0] gnt_addr;
    logic [7:0]        gnt_wdata;

    function automatic logic [LINES-1:0] onehot(input logic [ADDR_W-1:0] a);
        return LINES'(1) << a;
    endfunction

    // On a tie the requester that did not win last time takes the bank.
    always_comb begin
        gnt_valid = req0 | req1;
        gnt_id    = 1'b0;
        if (req0 && req1)
            gnt_id = ~last;
        else if (req1)
            gnt_id = 1'b1;
        gnt_we    = gnt_id ? we1    : we0;
        gnt_addr  = gnt_id ? addr1  : addr0;
        gnt_wdata = gnt_id ? wdata1 : wdata0;
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state     <= CLEAR;
            cnt       <= '0;
            owner     <= 1'b0;
            last      <= 1'b1;
            lat_we    <= 1'b0;
            lat_addr  <= '0;
            lat_wdata <= '0;
            rdata0    <= '0;
            rdata1    <= '0;
        end else begin
            case (state)
                CLEAR: begin
                    if (cnt == ADDR_W'(LINES - 1)) begin
                        state <= IDLE;
                        cnt   <= '0;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                IDLE: begin
                    if (gnt_valid) begin
                        state     <= ACCESS;
                        owner     <= gnt_id;
                        last      <= gnt_id;
                        lat_we    <= gnt_we;
                        lat_addr  <= gnt_addr;
                        lat_wdata <= gnt_wdata;
                    end
                end
                ACCESS: begin
                    if (!lat_we) begin
                        if (owner)
                            rdata1 <= mem_rdata;
                        else
                            rdata0 <= mem_rdata;
                    end
                    state <= ACK;
                end
                ACK:     state <= IDLE;
                default: state <= CLEAR;
            endcase
        end
    end

    // Bank-side and handshake outputs depend on registers only.
    always_comb begin
        mem_select = '0;
        mem_wE     = 1'b0;
        mem_rE     = 1'b0;
        mem_wdata  = '0;
        case (state)
            CLEAR: begin
                mem_select = onehot(cnt);
                mem_wE     = 1'b1;
            end
            ACCESS: begin
                mem_select = onehot(lat_addr);
                mem_wdata  = lat_wdata;
                mem_wE     = lat_we;
                mem_rE     = ~lat_we;
            end
            default: ;
        endcase
    end

    assign ack0 = (state == ACK) && !owner;
    assign ack1 = (state == ACK) &&  owner;
    assign busy = (state != IDLE);

endmodule

// File: tb/tb_mem_line_arbiter.sv
// Bench for mem_line_arbiter: models the bank and checks grants, data and timing
// against a transaction-level reference (model memory, round-robin last winner).
module tb_mem_line_arbiter;
    localparam int ADDR_W = 2;
    localparam int LINES  = 4;

    logic              clock = 1'b0;
    logic              reset = 1'b1;
    logic              req0 = 0, req1 = 0, we0 = 0, we1 = 0;
    logic [ADDR_W-1:0] addr0 = 0, addr1 = 0;
    logic [7:0]        wdata0 = 0, wdata1 = 0;
    logic              ack0, ack1, mem_rE, mem_wE, busy;
    logic [7:0]        rdata0, rdata1, mem_wdata, mem_rdata;
    logic [LINES-1:0]  mem_select;

    logic              fill = 1'b0;
    logic [7:0]        bank [LINES];

    int n_cmp = 0;
    int n_err = 0;

    logic [7:0] m_mem [LINES];
    logic [7:0] m_rd  [2];
    int         m_last;

    mem_line_arbiter #(.ADDR_W(ADDR_W)) dut (
        .clock(clock), .reset(reset),
        .req0(req0), .req1(req1), .we0(we0), .we1(we1),
        .addr0(addr0), .addr1(addr1), .wdata0(wdata0), .wdata1(wdata1),
        .ack0(ack0), .ack1(ack1), .rdata0(rdata0), .rdata1(rdata1),
        .mem_select(mem_select), .mem_rE(mem_rE), .mem_wE(mem_wE),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .busy(busy)
    );

    always #5 clock = ~clock;

    // Bank: fill preloads non-zero junk so a cleared line is distinguishable.
    always @(posedge clock) begin
        for (int i = 0; i < LINES; i++) begin
            if (fill)
                bank[i] <= 8'h80 | 8'(i + 1);
            else if (mem_wE && mem_select[i])
                bank[i] <= mem_wdata;
        end
    end

    always_comb begin
        mem_rdata = 8'h00;
        for (int i = 0; i < LINES; i++)
            if (mem_select[i]) mem_rdata = bank[i];
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, got timeout want finish");
        $fatal(1);
    end

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic model_reset();
        for (int i = 0; i < LINES; i++) m_mem[i] = 8'h00;
        m_rd[0] = 8'h00;
        m_rd[1] = 8'h00;
        m_last  = 1;
    endtask

    task automatic drive(input int id, input logic r, input logic w,
                         input logic [ADDR_W-1:0] a, input logic [7:0] d);
        if (id == 0) begin
            req0 = r; we0 = w; addr0 = a; wdata0 = d;
        end else begin
            req1 = r; we1 = w; addr1 = a; wdata1 = d;
        end
    endtask

    // Single-requester transaction driver; returns in the ACK cycle.
    task automatic run_txn(input int id, input logic w, input logic [ADDR_W-1:0] a,
                           input logic [7:0] d, output int lat, output bit got);
        drive(id, 1'b1, w, a, d);
        lat = 0;
        got = 0;
        for (int k = 1; k <= 8; k++) begin
            tick();
            if ((id == 0) ? ack0 : ack1) begin
                lat = k;
                got = 1;
                break;
            end
        end
        drive(id, 1'b0, w, a, d);
        if (got) begin
            m_last = id;
            if (w) m_mem[a] = d;
            else   m_rd[id] = m_mem[a];
        end
    endtask

    task automatic test_reset();
        fill = 1'b1;
        reset = 1'b1;
        tick();
        tick();
        fill = 1'b0;
        reset = 1'b0;
        model_reset();
        n_cmp++;
        if ({ack0, ack1, rdata0, rdata1, mem_rE, mem_wdata} !== {2'b00, 16'h0000, 1'b0, 8'h00}) begin
            n_err++;
            $display("FAIL reset_outputs: got ack=%b%b rd=%h/%h rE=%b wd=%h want zeros",
                     ack0, ack1, rdata0, rdata1, mem_rE, mem_wdata);
        end
        for (int i = 0; i < LINES; i++) begin
            n_cmp++;
            if (mem_select !== LINES'(1 << i) || mem_wE !== 1'b1 || busy !== 1'b1) begin
                n_err++;
                $display("FAIL clear_cycle%0d: got sel=%b wE=%b busy=%b want sel=%b wE=1 busy=1",
                         i, mem_select, mem_wE, busy, LINES'(1 << i));
            end
            tick();
        end
        n_cmp++;
        if (busy !== 1'b0 || mem_select !== '0 || mem_wE !== 1'b0) begin
            n_err++;
            $display("FAIL idle_after_clear: got busy=%b sel=%b wE=%b want 0/0000/0", busy, mem_select, mem_wE);
        end
        for (int i = 0; i < LINES; i++) begin
            n_cmp++;
            if (bank[i] !== 8'h00) begin
                n_err++;
                $display("FAIL bank_cleared%0d: got %h want 00", i, bank[i]);
            end
        end
    endtask

    task automatic test_write_read();
        int lat;
        bit got;
        drive(0, 1'b1, 1'b1, 2'd2, 8'hA5);
        tick();
        n_cmp++;
        if (mem_select !== 4'b0100 || mem_wE !== 1'b1 || mem_rE !== 1'b0 || mem_wdata !== 8'hA5 || ack0 !== 1'b0) begin
            n_err++;
            $display("FAIL write_access: got sel=%b wE=%b rE=%b wd=%h ack0=%b want 0100 1 0 a5 0",
                     mem_select, mem_wE, mem_rE, mem_wdata, ack0);
        end
        tick();
        n_cmp++;
        if (ack0 !== 1'b1 || ack1 !== 1'b0 || mem_wE !== 1'b0 || mem_rE !== 1'b0) begin
            n_err++;
            $display("FAIL write_ack: got ack0=%b ack1=%b wE=%b rE=%b want 1 0 0 0", ack0, ack1, mem_wE, mem_rE);
        end
        drive(0, 1'b0, 1'b0, 2'd0, 8'h00);
        m_mem[2] = 8'hA5;
        m_last = 0;
        tick();
        run_txn(0, 1'b0, 2'd2, 8'h00, lat, got);
        n_cmp++;
        if (!got || lat != 2 || rdata0 !== m_mem[2]) begin
            n_err++;
            $display("FAIL read_after_write: got ack=%0d lat=%0d rdata0=%h want ack=1 lat=2 rdata0=%h",
                     got, lat, rdata0, m_mem[2]);
        end
        tick();
    endtask

    task automatic test_unwritten_read();
        int lat;
        bit got;
        run_txn(1, 1'b0, 2'd3, 8'h00, lat, got);
        n_cmp++;
        if (!got || lat != 2 || rdata1 !== 8'h00 || rdata0 !== m_rd[0]) begin
            n_err++;
            $display("FAIL unwritten_read: got ack=%0d lat=%0d rd1=%h rd0=%h want 1 2 00 %h",
                     got, lat, rdata1, rdata0, m_rd[0]);
        end
        tick();
    endtask

    task automatic test_tie_alternate();
        int k;
        int exp_w;
        fill = 1'b1;
        reset = 1'b1;
        tick();
        fill = 1'b0;
        reset = 1'b0;
        model_reset();
        drive(0, 1'b1, 1'b0, 2'd0, 8'h00);
        drive(1, 1'b1, 1'b0, 2'd3, 8'h00);
        for (int g = 0; g < 4; g++) begin
            exp_w = 1 - m_last;
            k = 0;
            for (int c = 1; c <= 10; c++) begin
                tick();
                if (ack0 || ack1) begin
                    k = c;
                    break;
                end
            end
            n_cmp++;
            if (k != ((g == 0) ? 6 : 3) || ack0 !== (exp_w == 0) || ack1 !== (exp_w == 1)) begin
                n_err++;
                $display("FAIL tie_grant%0d: got wait=%0d ack0=%b ack1=%b want wait=%0d winner=%0d",
                         g, k, ack0, ack1, (g == 0) ? 6 : 3, exp_w);
            end
            m_last = exp_w;
            m_rd[exp_w] = 8'h00;
            n_cmp++;
            if (rdata0 !== m_rd[0] || rdata1 !== m_rd[1]) begin
                n_err++;
                $display("FAIL tie_rdata%0d: got %h/%h want %h/%h", g, rdata0, rdata1, m_rd[0], m_rd[1]);
            end
        end
        drive(0, 1'b0, 1'b0, 2'd0, 8'h00);
        drive(1, 1'b0, 1'b0, 2'd0, 8'h00);
        tick();
    endtask

    task automatic test_reset_mid_access();
        int lat;
        bit got;
        bit saw_ack;
        drive(0, 1'b1, 1'b1, 2'd1, 8'h3C);
        tick();
        reset = 1'b1;
        fill = 1'b1;
        drive(0, 1'b0, 1'b0, 2'd0, 8'h00);
        tick();
        reset = 1'b0;
        fill = 1'b0;
        model_reset();
        saw_ack = 0;
        for (int i = 0; i < LINES; i++) begin
            if (ack0 || ack1) saw_ack = 1;
            n_cmp++;
            if (mem_select !== LINES'(1 << i) || mem_wE !== 1'b1) begin
                n_err++;
                $display("FAIL rerun_clear%0d: got sel=%b wE=%b want %b 1", i, mem_select, mem_wE, LINES'(1 << i));
            end
            tick();
        end
        n_cmp++;
        if (saw_ack) begin
            n_err++;
            $display("FAIL dropped_no_ack: got ack during clear want none");
        end
        run_txn(0, 1'b0, 2'd1, 8'h00, lat, got);
        n_cmp++;
        if (!got || rdata0 !== 8'h00) begin
            n_err++;
            $display("FAIL read_after_abort: got ack=%0d rdata0=%h want 1 00", got, rdata0);
        end
        tick();
    endtask

    task automatic test_read_hold();
        int lat;
        bit got;
        run_txn(1, 1'b1, 2'd0, 8'h11, lat, got);
        tick();
        run_txn(0, 1'b0, 2'd0, 8'h00, lat, got);
        n_cmp++;
        if (!got || rdata0 !== 8'h11) begin
            n_err++;
            $display("FAIL hold_read: got ack=%0d rdata0=%h want 1 11", got, rdata0);
        end
        tick();
        drive(0, 1'b1, 1'b1, 2'd0, 8'h77);
        for (int c = 0; c < 3; c++) begin
            tick();
            if (c == 1) drive(0, 1'b0, 1'b0, 2'd0, 8'h00);
            n_cmp++;
            if (rdata0 !== 8'h11 || ack0 !== (c == 1)) begin
                n_err++;
                $display("FAIL hold_write%0d: got rdata0=%h ack0=%b want 11 %0d", c, rdata0, ack0, c == 1);
            end
        end
        m_mem[0] = 8'h77;
        m_last = 0;
    endtask

    task automatic test_random();
        logic              w_r [2];
        logic [ADDR_W-1:0] a_r [2];
        logic [7:0]        d_r [2];
        bit                pend [2];
        int                pat, win;
        bit                hit;
        for (int r = 0; r < 60; r++) begin
            pat = $urandom_range(1, 3);
            for (int id = 0; id < 2; id++) begin
                pend[id] = pat[id];
                w_r[id]  = 1'($urandom_range(0, 1));
                a_r[id]  = ADDR_W'($urandom_range(0, LINES - 1));
                d_r[id]  = 8'($urandom);
                drive(id, pend[id], w_r[id], a_r[id], d_r[id]);
            end
            while (pend[0] || pend[1]) begin
                win = (pend[0] && pend[1]) ? 1 - m_last : (pend[0] ? 0 : 1);
                hit = 0;
                for (int c = 1; c <= 8; c++) begin
                    tick();
                    if (ack0 || ack1) begin
                        hit = 1;
                        break;
                    end
                end
                if (w_r[win]) m_mem[a_r[win]] = d_r[win];
                else          m_rd[win] = m_mem[a_r[win]];
                m_last = win;
                n_cmp++;
                if (!hit || ack0 !== (win == 0) || ack1 !== (win == 1) ||
                    rdata0 !== m_rd[0] || rdata1 !== m_rd[1]) begin
                    n_err++;
                    $display("FAIL random%0d: got ack=%b%b rd=%h/%h want winner=%0d rd=%h/%h",
                             r, ack0, ack1, rdata0, rdata1, win, m_rd[0], m_rd[1]);
                    drive(0, 1'b0, 1'b0, 2'd0, 8'h00);
                    drive(1, 1'b0, 1'b0, 2'd0, 8'h00);
                    tick();
                    tick();
                    tick();
                    return;
                end
                pend[win] = 0;
                drive(win, 1'b0, 1'b0, 2'd0, 8'h00);
            end
            tick();
        end
    endtask

    initial begin
        test_reset();
        test_write_read();
        test_unwritten_read();
        test_tie_alternate();
        test_reset_mid_access();
        test_read_hold();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
